// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX among NUM_REQ byte producers.
// Optional frame watchdog enabled by defining ARB_TIMEOUT_EN.
package uart_tx_arbiter_pkg;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_tx_start,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic [clogb2(NUM_REQ)-1:0]    o_owner,
  output logic                          o_timeout
);

  localparam int NB_OWNER = clogb2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NB_OWNER-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic                    start_q, start_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    busy_q, busy_d;
  logic [NB_OWNER-1:0]     owner_q, owner_d;

  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic                    found;
  logic [NB_OWNER-1:0]     win;
  logic [NB_OWNER-1:0]     idx;
  logic [NB_OWNER-1:0]     nxt_ptr;
  logic                    done_ok;

`ifdef ARB_TIMEOUT_EN
  localparam int NB_CNT = clogb2(TIMEOUT_CYCLES);
  logic [NB_CNT-1:0]       cnt_q, cnt_d;
  logic                    tmo_q, tmo_d;
`endif

  // Unpack the flat requester data bus into per-requester bytes.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      data_arr[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First active request searching upward from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = NB_OWNER'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign nxt_ptr = (owner_q == NB_OWNER'(NUM_REQ - 1)) ?
                   '0 : owner_q + 1'b1;

  // Done is only trusted from the cycle after the start pulse.
  assign done_ok = i_tx_done && !start_q;

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = '0;
    start_d  = 1'b0;
    data_d   = data_q;
    busy_d   = busy_q;
    owner_d  = owner_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = NUM_REQ'(1) << win;
          start_d = 1'b1;
          data_d  = data_arr[win];
          owner_d = win;
          busy_d  = 1'b1;
          state_d = S_WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT_DONE: begin
        if (done_ok) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == NB_CNT'(TIMEOUT_CYCLES - 1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = nxt_ptr;
          tmo_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      owner_q  <= owner_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign o_grant    = grant_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_busy     = busy_q;
  assign o_owner    = owner_q;
`ifdef ARB_TIMEOUT_EN
  assign o_timeout  = tmo_q;
`else
  assign o_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed and random frames
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 100;
`ifdef ARB_TIMEOUT_EN
  localparam int LONG = 50;
`else
  localparam int LONG = 200;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N*W-1:0] data;
  logic         done;
  logic [N-1:0] grant;
  logic         start;
  logic [W-1:0] txd;
  logic         busy;
  logic [1:0]   owner;
  logic         tmo;

  int ncmp = 0;
  int nerr = 0;
  int ptr = 0;
  int last_owner = 0;
  logic [W-1:0] last_byte = '0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_req(req),
    .i_data(data),
    .o_grant(grant),
    .o_tx_start(start),
    .o_tx_data(txd),
    .i_tx_done(done),
    .o_busy(busy),
    .o_owner(owner),
    .o_timeout(tmo)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic zero_chk(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_data"},  32'(txd),   0);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_owner"}, 32'(owner), 0);
    chk({tag, "_tmo"},   32'(tmo),   0);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_tmo"},   32'(tmo),   0);
    chk({tag, "_owner"}, 32'(owner), 32'(last_owner));
    chk({tag, "_data"},  32'(txd),   32'(last_byte));
  endtask

  // One complete transaction: request, grant, hold, done.
  task automatic frame(input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input int dly, input bit glitch);
    int w;
    logic [W-1:0] b;
    req  = r;
    data = d;
    tick;
    w = pick(r, ptr);
    if (w < 0) begin
      idle_chk("noreq");
      return;
    end
    b = d[w*W +: W];
    chk("g_grant", 32'(grant), 32'(1) << w);
    chk("g_start", 32'(start), 1);
    chk("g_busy",  32'(busy),  1);
    chk("g_data",  32'(txd),   32'(b));
    chk("g_owner", 32'(owner), 32'(w));
    chk("g_tmo",   32'(tmo),   0);
    last_owner = w;
    last_byte  = b;
    req[w] = 1'b0;
    done = glitch;
    for (int i = 0; i < dly; i++) begin
      tick;
      done = 1'b0;
      chk("w_busy",  32'(busy),  1);
      chk("w_start", 32'(start), 0);
      chk("w_grant", 32'(grant), 0);
      chk("w_data",  32'(txd),   32'(b));
      chk("w_tmo",   32'(tmo),   0);
      req  = N'($urandom);
      data = $urandom;
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    req  = '0;
    idle_chk("d");
    ptr = (w + 1) % N;
  endtask

  initial begin
    int w;
    rst  = 1'b1;
    req  = '1;
    data = $urandom;
    done = 1'b0;

    repeat (3) begin
      tick;
      zero_chk("rst");
    end
    rst = 1'b0;
    ptr = 0;
    frame('1, data, 5, 1'b0);

    frame(4'b0010, 32'h0000_4100, LONG, 1'b0);
    chk("single_owner", 32'(owner), 1);

    rst = 1'b1;
    tick;
    rst = 1'b0;
    zero_chk("rst2");
    ptr = 0;
    last_owner = 0;
    last_byte = '0;
    for (int k = 0; k < 5; k++) begin
      frame('1, 32'hA3A2_A1A0, 10, k == 1);
      chk("fair_owner", 32'(owner), 32'(k % N));
    end

    frame(4'b0100, $urandom, 3, 1'b0);
    chk("r2_owner", 32'(owner), 2);
    frame(4'b1001, $urandom, 3, 1'b0);
    chk("rr_first", 32'(owner), 3);
    frame(4'b1001, $urandom, 3, 1'b0);
    chk("rr_second", 32'(owner), 0);

    done = 1'b1;
    tick;
    done = 1'b0;
    idle_chk("idle_done");
    tick;
    idle_chk("idle_done2");
    frame('1, $urandom, 2, 1'b0);
    chk("ptr_kept", 32'(owner), 1);

    req  = 4'b1000;
    data = $urandom;
    tick;
    chk("mid_busy", 32'(busy), 1);
    req = '0;
    repeat (5) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    zero_chk("rst_mid");
    ptr = 0;
    last_owner = 0;
    last_byte = '0;
    frame(4'b0101, $urandom, 4, 1'b0);
    chk("ptr_zero", 32'(owner), 0);
    frame(4'b0100, $urandom, 4, 1'b0);
    chk("after_rst", 32'(owner), 2);

    repeat (25) begin
      frame(N'($urandom), $urandom, $urandom_range(1, 20),
            $urandom_range(0, 3) == 0);
    end

    req  = 4'b0001;
    data = $urandom;
    tick;
    w = 0;
    chk("t_start", 32'(start), 1);
    chk("t_owner", 32'(owner), 0);
    req = '0;
`ifdef ARB_TIMEOUT_EN
    repeat (TO - 1) begin
      tick;
      chk("t_wait", {30'd0, busy, tmo}, 32'b10);
    end
    tick;
    chk("t_pulse", 32'(tmo), 1);
    chk("t_busy",  32'(busy), 0);
    ptr = (w + 1) % N;
    tick;
    chk("t_clear", 32'(tmo), 0);
    frame('1, $urandom, 2, 1'b0);
    chk("t_next", 32'(owner), 32'((w + 1) % N));
`else
    repeat (1000) begin
      tick;
      chk("t_hold", {30'd0, busy, tmo}, 32'b10);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("t_done", 32'(busy), 0);
    ptr = (w + 1) % N;
    frame('1, $urandom, 2, 1'b0);
    chk("t_next", 32'(owner), 32'((w + 1) % N));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
